mux_arb_nx1: RTL and testbench

- Registered N-channel, WIDTH-bit multiplexer with valid/ready handshake on every input and on the output.
- Two selection modes: fixed (external select) and round-robin arbitration.
- Sits between multiple datapath producers (e.g. register-file read ports, forwarding sources) and a single consumer stage.
- Provides one cycle of buffering and a full throughput of one transfer per clock.

---
 rtl/mux_arb_nx1_if.sv | 37 +++
 rtl/mux_arb_nx1.sv | 77 +++++++
 tb/tb_mux_arb_nx1.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_nx1_if.sv
// Handshake bundle between N_CH producers, the selector/arbiter, and one consumer.
//   mode      : 0 = fixed select via sel, 1 = round-robin
//   sel       : channel index used in fixed mode
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready
//   out_data  : selected data
//   out_valid : output valid
//   out_ready : consumer ready
//   out_sel   : index of the channel whose data is in out_data
// The slave modport is the mux side; the master modport is the environment side.
interface mux_arb_nx1_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 64
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_W-1:0]      out_sel;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_arb_nx1.sv
// Registered N-channel multiplexer/arbiter with valid/ready on every input and the output.
// Fixed mode forwards the channel named by sel; round-robin mode grants the first valid
// channel after the last granted one. One output register gives 1-cycle latency and full
// throughput (a drain and a load may happen on the same edge).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_arb_nx1_if slave modport (mode/sel, input channels, output channel)
// N_CH and WIDTH must match the parameters of the connected interface.
module mux_arb_nx1 #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 64
) (
  input logic          clk,
  input logic          rst_n,
  mux_arb_nx1_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] out_sel_q;
  logic [SEL_W-1:0] last_grant_q;

  logic             load_en;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [N_CH-1:0]  grant;

  assign load_en = !out_valid_q || bus.out_ready;

  // Grant search. Round-robin walks forward from last_grant+1, wrapping at N_CH.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (!bus.mode) begin
      if ((32'(bus.sel) < N_CH) && bus.in_valid[bus.sel]) begin
        grant_any = 1'b1;
        grant_idx = bus.sel;
      end
    end else begin
      for (int unsigned k = 1; k <= N_CH; k++) begin
        if (!grant_any && bus.in_valid[(32'(last_grant_q) + k) % N_CH]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'((32'(last_grant_q) + k) % N_CH);
        end
      end
    end
  end

  assign grant        = grant_any ? (N_CH'(1) << grant_idx) : '0;
  // Held low during reset so no producer believes a word was accepted.
  assign bus.in_ready = (rst_n && load_en) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sel_q    <= '0;
      last_grant_q <= SEL_W'(N_CH - 1);
    end else if (load_en) begin
      if (grant_any) begin
        out_data_q   <= bus.in_data[32'(grant_idx) * WIDTH +: WIDTH];
        out_sel_q    <= grant_idx;
        out_valid_q  <= 1'b1;
        last_grant_q <= grant_idx;
      end else begin
        // Drained (or idle) with nothing new: data and sel keep their last values.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_arb_nx1.sv
module tb_mux_arb_nx1;
  localparam int N = 4;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  always #5 clk = ~clk;

  mux_arb_nx1_if #(.N_CH(N), .WIDTH(W)) bus ();

  mux_arb_nx1 #(.N_CH(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the consumer should see, from the selection rules alone.
  logic        m_valid = 1'b0;
  logic [63:0] m_data  = '0;
  int          m_sel   = 0;
  int          m_ptr   = N - 1;
  int          m_pick;

  function automatic int pick(input logic md, input logic [1:0] s, input logic [3:0] v,
                              input int ptr);
    if (!md) return v[s] ? int'(s) : -1;
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always_comb m_pick = pick(bus.mode, bus.sel, bus.in_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 0;
      m_ptr   <= N - 1;
    end else if (!m_valid || bus.out_ready) begin
      if (m_pick >= 0) begin
        m_valid <= 1'b1;
        m_data  <= bus.in_data[m_pick*W +: W];
        m_sel   <= m_pick;
        m_ptr   <= m_pick;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] er;
      er = '0;
      if (rst_n && (!m_valid || bus.out_ready) && m_pick >= 0) er[m_pick] = 1'b1;
      chk("model in_ready", 64'(bus.in_ready), 64'(er));
      chk("model out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("model out_data", bus.out_data, m_data);
      chk("model out_sel", 64'(bus.out_sel), 64'(m_sel));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [63:0] v);
    bus.in_data[i*W +: W] = v;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_data", bus.out_data, 64'd0);
    chk("reset out_sel", 64'(bus.out_sel), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: fixed select of ch2
    bus.sel = 2'd2; bus.in_valid = 4'b0100; set_ch(2, 64'hAAAA); bus.out_ready = 1'b1;
    #1 chk("t1 in_ready", 64'(bus.in_ready), 64'h4);
    step();
    chk("t1 out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1 out_data", bus.out_data, 64'hAAAA);
    chk("t1 out_sel", 64'(bus.out_sel), 64'd2);

    // 2: fixed select of an invalid channel ignores the others
    bus.sel = 2'd1; bus.in_valid = 4'b1101;
    #1 chk("t2 in_ready", 64'(bus.in_ready), 64'h0);
    step();
    chk("t2 out_valid", 64'(bus.out_valid), 64'd0);
    chk("t2 out_data hold", bus.out_data, 64'hAAAA);
    chk("t2 out_sel hold", 64'(bus.out_sel), 64'd2);

    // 3: round-robin over all four channels from a fresh pointer
    rst_n = 1'b0; #2 rst_n = 1'b1;
    bus.mode = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 64'(10 + i));
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3 out_valid", 64'(bus.out_valid), 64'd1);
      chk("t3 out_sel", 64'(bus.out_sel), 64'(i % 4));
      chk("t3 out_data", bus.out_data, 64'(10 + i % 4));
    end

    // 4: stall with ch3 held, then release with only ch1 valid
    bus.out_ready = 1'b0; bus.in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4 stall in_ready", 64'(bus.in_ready), 64'h0);
      step();
      chk("t4 stall out_sel", 64'(bus.out_sel), 64'd3);
      chk("t4 stall out_data", bus.out_data, 64'd13);
      chk("t4 stall out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1 chk("t4 release in_ready", 64'(bus.in_ready), 64'h2);
    step();
    chk("t4 out_sel", 64'(bus.out_sel), 64'd1);
    chk("t4 out_valid", 64'(bus.out_valid), 64'd1);
    chk("t4 out_data", bus.out_data, 64'd11);

    // 5: wrap from last_grant = 3 to ch0, then ch3
    bus.in_valid = 4'b1000;
    step();
    chk("t5 prime sel", 64'(bus.out_sel), 64'd3);
    bus.in_valid = 4'b1001;
    step();
    chk("t5 wrap sel", 64'(bus.out_sel), 64'd0);
    step();
    chk("t5 next sel", 64'(bus.out_sel), 64'd3);
    step();
    chk("t5 pre-reset valid", 64'(bus.out_valid), 64'd1);

    // 6: asynchronous reset mid-cycle; X data must not leak
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6 async out_data", bus.out_data, 64'd0);
    chk("t6 async in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_data = 'x;
    step();
    chk("t6 x out_data", bus.out_data, 64'd0);
    chk("t6 x out_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < N; i++) set_ch(i, 64'(20 + i));
    bus.in_valid = 4'b1111;
    rst_n = 1'b1;
    step();
    chk("t6 first sel", 64'(bus.out_sel), 64'd0);
    chk("t6 first data", bus.out_data, 64'd20);
    step();
    chk("t6 second sel", 64'(bus.out_sel), 64'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
